// File: rtl/boot_loader_ctrl_if.sv
// Loader byte stream, CPU data-port request and RAM data-port bundle for boot_loader_ctrl.
// The controller connects through the slave modport; the byte source and CPU side use master.
interface boot_loader_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_wr;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              ram_wr;

    modport master (
        output in_valid, in_data, cpu_addr, cpu_wdata, cpu_wr,
        input  in_ready, ram_addr, ram_wdata, ram_wr
    );

    modport slave (
        input  in_valid, in_data, cpu_addr, cpu_wdata, cpu_wr,
        output in_ready, ram_addr, ram_wdata, ram_wr
    );
endinterface

// File: rtl/boot_loader_ctrl.sv
// Boot loader: holds the CPU in reset, writes a length-prefixed little-endian word
// stream into RAM through the data port, then hands the port over and releases the CPU.
module boot_loader_ctrl #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h0000_0000),
    parameter int                MEM_WORDS = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    boot_loader_ctrl_if.slave   bus,
    output logic                cpu_rst_n,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam int IDX_W = $clog2(MEM_WORDS + 1);

    localparam logic [2:0] ST_HDR   = 3'd0;
    localparam logic [2:0] ST_DATA  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    logic [2:0]        state_r;
    logic [2:0]        state_nxt_s;
    logic [1:0]        bcnt_r;
    logic [23:0]       shift_r;
    logic [31:0]       count_r;
    logic [IDX_W-1:0]  idx_r;
    logic [IDX_W-1:0]  idx_inc_s;
    logic [ADDR_W-1:0] ram_addr_r;
    logic [31:0]       ram_wdata_r;
    logic              ram_wr_r;
    logic              cpu_rst_n_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;

    logic              in_ready_s;
    logic              accept_s;
    logic              last_byte_s;
    logic [31:0]       word_s;
    logic              cpu_owns_s;

    assign in_ready_s  = rst_n & ((state_r == ST_HDR) | (state_r == ST_DATA));
    assign accept_s    = bus.in_valid & in_ready_s;
    assign last_byte_s = accept_s & (bcnt_r == 2'd3);
    assign word_s      = {bus.in_data, shift_r};
    assign idx_inc_s   = idx_r + IDX_W'(1'b1);
    // The CPU only reaches the RAM port once both the state and its released reset agree.
    assign cpu_owns_s  = (state_r == ST_RUN) & cpu_rst_n_r;

    // Next-state decode for the load sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_HDR: begin
                if (last_byte_s) begin
                    if (word_s == 32'd0) begin
                        state_nxt_s = ST_RUN;
                    end else if (word_s > 32'(MEM_WORDS)) begin
                        state_nxt_s = ST_ERR;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_HDR;
                end
            end
            ST_DATA: begin
                if (last_byte_s) begin
                    state_nxt_s = ST_WRITE;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_WRITE: begin
                if (32'(idx_inc_s) == count_r) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_RUN:  state_nxt_s = ST_RUN;
            ST_ERR:  state_nxt_s = ST_ERR;
            // An undefined encoding parks the block with the CPU held in reset.
            default: state_nxt_s = ST_ERR;
        endcase
    end

    // State, byte assembly, word index and registered status/write outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_HDR;
            bcnt_r      <= 2'd0;
            shift_r     <= 24'd0;
            count_r     <= 32'd0;
            idx_r       <= '0;
            ram_addr_r  <= '0;
            ram_wdata_r <= 32'd0;
            ram_wr_r    <= 1'b0;
            cpu_rst_n_r <= 1'b0;
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            ram_wr_r <= 1'b0;

            if (accept_s) begin
                bcnt_r <= bcnt_r + 2'd1;
                case (bcnt_r)
                    2'd0:    shift_r[7:0]   <= bus.in_data;
                    2'd1:    shift_r[15:8]  <= bus.in_data;
                    2'd2:    shift_r[23:16] <= bus.in_data;
                    default: shift_r        <= shift_r;
                endcase
            end

            if (last_byte_s && (state_r == ST_HDR)) begin
                count_r <= word_s;
                idx_r   <= '0;
            end

            // The RAM write is issued in the WRITE cycle that follows the completing byte.
            if (last_byte_s && (state_r == ST_DATA)) begin
                ram_addr_r  <= BASE_ADDR + (ADDR_W'(idx_r) << 2);
                ram_wdata_r <= word_s;
                ram_wr_r    <= 1'b1;
            end

            if (state_r == ST_WRITE) begin
                idx_r <= idx_inc_s;
            end

            cpu_rst_n_r <= (state_nxt_s == ST_RUN);
            done_r      <= (state_nxt_s == ST_RUN);
            err_r       <= (state_nxt_s == ST_ERR);
            busy_r      <= (state_nxt_s != ST_RUN) && (state_nxt_s != ST_ERR);
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.ram_addr  = cpu_owns_s ? bus.cpu_addr  : ram_addr_r;
    assign bus.ram_wdata = cpu_owns_s ? bus.cpu_wdata : ram_wdata_r;
    assign bus.ram_wr    = rst_n & (cpu_owns_s ? bus.cpu_wr : ram_wr_r);

    assign cpu_rst_n = cpu_rst_n_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Bench for boot_loader_ctrl: expected RAM writes are queued as stimulus is driven and
// popped by a write monitor on the falling edge; per-scenario tasks check control outputs.
module tb_boot_loader_ctrl;
    localparam int ADDR_W    = 32;
    localparam int MEM_WORDS = 1024;

    logic clk = 1'b0;
    logic rst_n;
    logic cpu_rst_n;
    logic busy;
    logic done;
    logic err;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [63:0] sb[$];
    logic [63:0] exp_w;

    boot_loader_ctrl_if #(.ADDR_W(ADDR_W)) bif();

    boot_loader_ctrl #(
        .ADDR_W(ADDR_W),
        .BASE_ADDR(32'h0000_0000),
        .MEM_WORDS(MEM_WORDS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bif),
        .cpu_rst_n(cpu_rst_n),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    // Every RAM write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bif.ram_wr === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL ram_write_unexpected: got addr=%h data=%h, required no write", bif.ram_addr, bif.ram_wdata);
            end else begin
                exp_w = sb.pop_front();
                if ({bif.ram_addr, bif.ram_wdata} !== exp_w) begin
                    n_fail++;
                    $display("FAIL ram_write: got addr=%h data=%h, required addr=%h data=%h",
                             bif.ram_addr, bif.ram_wdata, exp_w[63:32], exp_w[31:0]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input bit check);
        rst_n         = 1'b0;
        bif.in_valid  = 1'b0;
        bif.in_data   = 8'h00;
        bif.cpu_addr  = 32'h0;
        bif.cpu_wdata = 32'h0;
        bif.cpu_wr    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        if (check) begin
            n_cmp++;
            if ({bif.in_ready, bif.ram_wr, cpu_rst_n, done, err} !== 5'b00000) begin
                n_fail++;
                $display("FAIL reset_hold: got ready,wr,cpu_rst_n,done,err=%b, required 00000",
                         {bif.in_ready, bif.ram_wr, cpu_rst_n, done, err});
            end
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        if (check) begin
            n_cmp++;
            if ({busy, bif.in_ready, cpu_rst_n} !== 3'b110) begin
                n_fail++;
                $display("FAIL reset_first_cycle: got busy,ready,cpu_rst_n=%b, required 110", {busy, bif.in_ready, cpu_rst_n});
            end
            n_cmp++;
            if ({bif.ram_addr, bif.ram_wdata} !== 64'h0) begin
                n_fail++;
                $display("FAIL reset_ram_bus: got addr=%h data=%h, required 0/0", bif.ram_addr, bif.ram_wdata);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Present one byte, wait for it to be accepted, then drop valid.
    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok           = 1'b0;
        bif.in_valid = 1'b1;
        bif.in_data  = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bif.in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL byte_accept_timeout: byte %h not accepted within 50 cycles", b);
        end
        @(posedge clk);
        #1 bif.in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
            if (i < 3) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    n_cmp++;
                    if (bif.in_ready !== 1'b1) begin
                        n_fail++;
                        $display("FAIL gap_ready: got in_ready=%b, required 1", bif.in_ready);
                    end
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic check_sb_empty(input string name);
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_pending: got %0d writes outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        do_reset(1'b1);
    endtask

    task automatic test_nominal();
        do_reset(1'b0);
        sb.push_back({32'h0000_0000, 32'h0000_0013});
        sb.push_back({32'h0000_0004, 32'h0000_006F});
        send_word(32'd2, 0);
        send_word(32'h0000_0013, 0);
        send_word(32'h0000_006F, 0);
        @(negedge clk);
        n_cmp++;
        if ({bif.ram_wr, cpu_rst_n} !== 2'b10) begin
            n_fail++;
            $display("FAIL nominal_last_write: got ram_wr,cpu_rst_n=%b, required 10", {bif.ram_wr, cpu_rst_n});
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if ({cpu_rst_n, done, busy, err} !== 4'b1100) begin
            n_fail++;
            $display("FAIL nominal_run: got cpu_rst_n,done,busy,err=%b, required 1100", {cpu_rst_n, done, busy, err});
        end
        check_sb_empty("nominal");
        @(posedge clk);
        #1;
    endtask

    task automatic test_passthrough();
        sb.push_back({32'h0000_0100, 32'h1234_5678});
        bif.cpu_addr  = 32'h0000_0100;
        bif.cpu_wdata = 32'h1234_5678;
        bif.cpu_wr    = 1'b1;
        bif.in_valid  = 1'b1;
        bif.in_data   = 8'hAA;
        #1;
        n_cmp++;
        if ({bif.ram_addr, bif.ram_wdata, bif.ram_wr} !== {32'h0000_0100, 32'h1234_5678, 1'b1}) begin
            n_fail++;
            $display("FAIL passthrough_same_cycle: got addr=%h data=%h wr=%b, required 00000100/12345678/1",
                     bif.ram_addr, bif.ram_wdata, bif.ram_wr);
        end
        @(negedge clk);
        @(posedge clk);
        #1 bif.cpu_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({bif.in_ready, done, bif.ram_wr} !== 3'b010) begin
                n_fail++;
                $display("FAIL passthrough_no_accept: got ready,done,wr=%b, required 010", {bif.in_ready, done, bif.ram_wr});
            end
        end
        @(posedge clk);
        #1 bif.in_valid = 1'b0;
        check_sb_empty("passthrough");
    endtask

    task automatic test_zero();
        do_reset(1'b0);
        send_word(32'd0, 0);
        @(negedge clk);
        n_cmp++;
        if ({cpu_rst_n, done, err, bif.ram_wr} !== 4'b1100) begin
            n_fail++;
            $display("FAIL zero_run: got cpu_rst_n,done,err,wr=%b, required 1100", {cpu_rst_n, done, err, bif.ram_wr});
        end
        repeat (3) @(posedge clk);
        #1;
        check_sb_empty("zero");
    endtask

    task automatic test_oversize();
        do_reset(1'b0);
        send_word(32'(MEM_WORDS + 1), 0);
        bif.in_valid = 1'b1;
        bif.in_data  = 8'h55;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({err, cpu_rst_n, bif.in_ready, busy, done} !== 5'b10000) begin
                n_fail++;
                $display("FAIL oversize_err: got err,cpu_rst_n,ready,busy,done=%b, required 10000",
                         {err, cpu_rst_n, bif.in_ready, busy, done});
            end
        end
        @(posedge clk);
        #1 bif.in_valid = 1'b0;
        do_reset(1'b0);
        send_word(32'(MEM_WORDS), 0);
        @(negedge clk);
        n_cmp++;
        if ({err, busy, bif.in_ready, cpu_rst_n} !== 4'b0110) begin
            n_fail++;
            $display("FAIL max_count_accepted: got err,busy,ready,cpu_rst_n=%b, required 0110",
                     {err, busy, bif.in_ready, cpu_rst_n});
        end
        @(posedge clk);
        #1;
        check_sb_empty("oversize");
    endtask

    task automatic test_gapped();
        do_reset(1'b0);
        sb.push_back({32'h0000_0000, 32'hDEAD_BEEF});
        send_word(32'd1, 0);
        send_word(32'hDEAD_BEEF, 3);
        @(negedge clk);
        n_cmp++;
        if ({bif.in_ready, bif.ram_wr} !== 2'b01) begin
            n_fail++;
            $display("FAIL gapped_write_cycle: got ready,wr=%b, required 01", {bif.in_ready, bif.ram_wr});
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if ({done, cpu_rst_n} !== 2'b11) begin
            n_fail++;
            $display("FAIL gapped_run: got done,cpu_rst_n=%b, required 11", {done, cpu_rst_n});
        end
        @(posedge clk);
        #1;
        check_sb_empty("gapped");
    endtask

    task automatic test_reset_midload();
        do_reset(1'b0);
        sb.push_back({32'h0000_0000, 32'h1111_1111});
        send_word(32'd3, 0);
        send_word(32'h1111_1111, 0);
        send_byte(8'h22);
        send_byte(8'h33);
        check_sb_empty("midload_first");
        do_reset(1'b0);
        n_cmp++;
        if ({cpu_rst_n, busy, bif.in_ready} !== 3'b011) begin
            n_fail++;
            $display("FAIL midload_after_reset: got cpu_rst_n,busy,ready=%b, required 011", {cpu_rst_n, busy, bif.in_ready});
        end
        sb.push_back({32'h0000_0000, 32'hCAFE_F00D});
        send_word(32'd1, 0);
        send_word(32'hCAFE_F00D, 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if ({done, cpu_rst_n} !== 2'b11) begin
            n_fail++;
            $display("FAIL midload_run: got done,cpu_rst_n=%b, required 11", {done, cpu_rst_n});
        end
        @(posedge clk);
        #1;
        check_sb_empty("midload");
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_passthrough();
        test_zero();
        test_oversize();
        test_gapped();
        test_reset_midload();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/boot_loader_ctrl.md
Name: boot_loader_ctrl

Overview:
- Sequences bring-up of the CPU core and the shared dual-port RAM data port.
- After reset it holds the CPU in reset and owns the RAM data/write port. It accepts a byte stream (32-bit little-endian word-count header, then program words) and writes the words into RAM.
- When loading completes it hands the RAM data port to the CPU and releases CPU reset. The instruction port is not touched.

Parameters:
- ADDR_W, 32, width of RAM/CPU address bus.
- BASE_ADDR, 32'h0000_0000, byte address of first loaded word (word-aligned).
- MEM_WORDS, 1024, maximum loadable word count.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  loader byte valid.
- in_data  in  8  loader byte.
- in_ready  out  1  block accepts byte this cycle.
- cpu_addr  in  ADDR_W  CPU data address.
- cpu_wdata  in  32  CPU write data.
- cpu_wr  in  1  CPU write strobe.
- ram_addr  out  ADDR_W  to RAM data-port address.
- ram_wdata  out  32  to RAM data-port write data.
- ram_wr  out  1  to RAM data-port write enable.
- cpu_rst_n  out  1  active-low reset to CPU core.
- busy  out  1  load in progress.
- done  out  1  load complete, CPU running.
- err  out  1  header count exceeded MEM_WORDS.

Behaviour:
- Clocking and reset: one clock, synchronous active-low reset.
- Reset values while rst_n=0 and on the first cycle after: state=HDR, cpu_rst_n=0, ram_wr=0, ram_addr=0, ram_wdata=0, in_ready=0 during reset, busy=1 after reset, done=0, err=0. Byte counter, word counter and shift register are all 0.
- Handshake: a byte transfers on a rising edge with in_valid&&in_ready. in_ready=1 only in HDR and DATA. in_data is ignored otherwise. in_valid may drop at any time; gaps are allowed.
- Byte assembly: little-endian. First byte accepted goes to bits [7:0], fourth byte to [31:24]. A 2-bit byte counter wraps 3->0.
- HDR state:
  - The 4th header byte latches count[31:0].
  - count==0: go to RUN next cycle.
  - count>MEM_WORDS: go to ERR.
  - Otherwise go to DATA with idx=0.
- DATA state: the 4th data byte latches the word and goes to WRITE.
- WRITE state (exactly 1 cycle):
  - ram_wr=1, ram_addr=BASE_ADDR+4*idx, ram_wdata=assembled word, in_ready=0.
  - Next: idx+1. If idx+1==count, go to RUN; else go to DATA.
  - Write latency: one cycle after the accepting edge of the 4th byte.
- RUN state (terminal until reset):
  - ram_addr/ram_wdata/ram_wr = cpu_addr/cpu_wdata/cpu_wr, combinational passthrough.
  - cpu_rst_n=1 registered; it rises on the first RUN cycle.
  - done=1, busy=0.
- ERR state (terminal until reset): cpu_rst_n=0, ram_wr=0, err=1, busy=0, done=0, in_ready=0.
- Port ownership: in all states other than RUN, cpu_* inputs are ignored and ram_wr comes only from the loader. The CPU can never write RAM while cpu_rst_n=0.
- Index width: idx is $clog2(MEM_WORDS+1) bits. The address computation has no wrap because count<=MEM_WORDS.
- Reset mid-load: any state returns to HDR with all counters cleared. Words already written remain in RAM. cpu_rst_n drops to 0 on the same edge.
- Simultaneous events: in_valid during WRITE/RUN/ERR is not accepted (in_ready=0). The header count is not re-read.

Test Plan:
- Nominal load:
  - Stimulus: bytes 02 00 00 00, 13 00 00 00, 6F 00 00 00 with in_valid held high.
  - Required: ram_wr pulses with (addr 0x0, data 0x00000013) then (addr 0x4, data 0x0000006F). cpu_rst_n=1 and done=1 on the cycle after the second write.
- Zero count:
  - Stimulus: header 00 00 00 00.
  - Required: no ram_wr. RUN and cpu_rst_n=1 one cycle after the 4th header byte.
- Oversize:
  - Stimulus: header with count=MEM_WORDS+1 (01 04 00 00 for default).
  - Required: err=1, cpu_rst_n stays 0, in_ready=0, no ram_wr for 20 cycles.
- Gapped stream:
  - Stimulus: count=1, word 0xDEADBEEF sent as EF BE AD DE with in_valid low 3 cycles between bytes.
  - Required: one write, addr 0x0, data 0xDEADBEEF. in_ready low only in the WRITE cycle.
- Reset mid-load:
  - Stimulus: count=3, assert rst_n=0 after the 6th data byte, then send a fresh count=1 stream.
  - Required: addr 0x0 is written with the new word. Counters restart; no write to 0x4 from the aborted partial word.
- RUN passthrough:
  - Stimulus: after load, drive cpu_addr=0x100, cpu_wdata=0x12345678, cpu_wr=1.
  - Required: ram_* outputs equal these values in the same cycle. Extra in_valid bytes are not accepted.
